order_ingress_arbiter: RTL and testbench
========================================

Name: order_ingress_arbiter

Overview:
Collects orders from NUM_PORTS independent gateway sources and issues them one per cycle, as single-cycle pulses, to the order matching engine's order input. Each port has a one-entry holding register with a valid/ready handshake. Ports are served round-robin. Optional pause and minimum inter-order gap throttle the matcher. Zero-quantity orders are rejected and counted.

Parameters:
NUM_PORTS, 4, number of requester ports (2..8)
PRICE_WIDTH, 32, price field width
QTY_WIDTH, 16, quantity field width
ID_WIDTH, 16, order ID width
MIN_GAP, 0, idle cycles forced after each issued order (0..15)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_PORTS  per-port order valid
req_ready  out  NUM_PORTS  per-port holding register empty
req_is_buy  in  NUM_PORTS  per-port side, 1=buy
req_price  in  NUM_PORTS*PRICE_WIDTH  port i at bits [i*PRICE_WIDTH +: PRICE_WIDTH]
req_qty  in  NUM_PORTS*QTY_WIDTH  packed like req_price
req_id  in  NUM_PORTS*ID_WIDTH  packed like req_price
pause  in  1  inhibit issuing while high
order_valid  out  1  one-cycle issue pulse to the matcher
order_is_buy  out  1  issued side
order_price  out  PRICE_WIDTH  issued price
order_qty  out  QTY_WIDTH  issued quantity
order_id  out  ID_WIDTH  issued ID
order_port  out  3  source port of the issued order
issued_count  out  32  total orders issued, wraps
reject_count  out  32  total zero-qty rejects, wraps
port_issued  out  NUM_PORTS*32  per-port issue counters (optional feature)

Behaviour:
- Reset values: all holding registers empty; req_ready all 1; order_valid, order_is_buy, order_price, order_qty, order_id, order_port, issued_count, reject_count, port_issued = 0; RR pointer = 0; FSM = ARB; gap counter = 0.
- req_ready[i] = !hold_valid[i]. It is registered and never depends on req_valid. An order is accepted at an edge where req_valid[i] && req_ready[i]. Payload is captured into hold[i].
- Zero-qty reject: an accepted order with qty == 0 is not stored. hold_valid stays 0 and reject_count increments. Simultaneous rejects on k ports in one cycle add k.
- FSM states: ARB, GAP.
  - ARB, pause = 0, at least one hold_valid set: grant the first set port scanning from the RR pointer upward, mod NUM_PORTS.
    - Registered outputs load hold[g] and order_port = g; order_valid = 1 the next cycle; hold_valid[g] clears.
    - RR pointer = (g+1) mod NUM_PORTS; issued_count += 1.
    - If MIN_GAP > 0, go to GAP with the counter at MIN_GAP.
  - ARB with pause = 1 or no pending order: no grant; order_valid = 0.
  - GAP: no grants; counter decrements each cycle; return to ARB at the edge where it reaches 1. Exactly MIN_GAP idle cycles follow each pulse.
  - pause does not stop the GAP countdown.
- order_valid lasts exactly one cycle per grant. The order_* payload holds its value between pulses.
- Latency with pause = 0, port idle, MIN_GAP = 0: accept at edge E0, grant at E1, order_valid high in the cycle after E1. Per-port throughput is 1 order per 2 cycles; aggregate throughput is 1 per cycle.
- The pause input affects only issuing; acceptance into holding registers continues.
- Simultaneous accept and grant on different ports are independent. A port cannot be accepted and granted in the same cycle.
- The RR pointer skips empty ports without advancing on idle cycles.
- rst asserted mid-operation: all pending held orders are discarded (not issued, not counted) and outputs return to reset values at the next edge. A pulse already driven completes that cycle.

Optional Feature:
Macro ARB_PORT_COUNTERS_EN.
- Defined: port_issued[i*32 +: 32] increments on each grant to port i, wraps at 2^32, and resets to 0.
- Undefined: port_issued is tied to 0 and no counter logic is built. All other behaviour is identical.

Test Plan:
- Single port: port 1 sends buy, price 100, qty 5, id 7 at edge E0 -> order_valid high the cycle after E1 with is_buy = 1, price 100, qty 5, id 7, order_port 1; issued_count = 1.
- All 4 ports load simultaneously, MIN_GAP = 0 -> pulses on 4 consecutive cycles with order_port 0,1,2,3. Refilling port 0 after its grant yields a grant order of 0,1,2,3,0 (no starvation).
- MIN_GAP = 3, ports 0 and 2 loaded -> pulse from port 0, exactly 3 idle cycles, then pulse from port 2.
- pause high for 10 cycles with ports 0 and 3 loaded -> no order_valid; req_ready[0] and req_ready[3] = 0; the first pulse comes 1 cycle after pause falls.
- Ports 1 and 2 send qty 0 in the same cycle -> reject_count = 2; no pulse; req_ready stays 1.
- rst for 1 cycle while 3 ports are held -> no subsequent pulse; counters = 0; req_ready all 1. With ARB_PORT_COUNTERS_EN defined, port_issued reads 0.

Source files
------------

// File: rtl/order_ingress_arbiter.sv
// Round-robin order ingress arbiter: per-port one-entry holding registers, one issue pulse per grant.
// Optional per-port issue counters are built when ARB_PORT_COUNTERS_EN is defined.
module order_ingress_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int PRICE_WIDTH = 32,
  parameter int QTY_WIDTH   = 16,
  parameter int ID_WIDTH    = 16,
  parameter int MIN_GAP     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_is_buy,
  input  logic [NUM_PORTS*PRICE_WIDTH-1:0] req_price,
  input  logic [NUM_PORTS*QTY_WIDTH-1:0]   req_qty,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]    req_id,
  input  logic                             pause,
  output logic                             order_valid,
  output logic                             order_is_buy,
  output logic [PRICE_WIDTH-1:0]           order_price,
  output logic [QTY_WIDTH-1:0]             order_qty,
  output logic [ID_WIDTH-1:0]              order_id,
  output logic [2:0]                       order_port,
  output logic [31:0]                      issued_count,
  output logic [31:0]                      reject_count,
  output logic [NUM_PORTS*32-1:0]          port_issued,
  output logic                             fsm_state
);
  typedef enum logic {ST_ARB = 1'b0, ST_GAP = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             gap_cnt_q, gap_cnt_d;
  logic [2:0]             rr_q;
  logic [NUM_PORTS-1:0]   hold_valid_q, hold_valid_d, hold_is_buy_q;
  logic [PRICE_WIDTH-1:0] hold_price_q [NUM_PORTS];
  logic [QTY_WIDTH-1:0]   hold_qty_q   [NUM_PORTS];
  logic [ID_WIDTH-1:0]    hold_id_q    [NUM_PORTS];

  logic [NUM_PORTS-1:0]   accept, reject, gnt_oh;
  logic [31:0]            reject_inc;
  logic [7:0]             hv_pad;
  logic [3:0]             scan;
  logic                   gnt_found, grant_en;
  logic [2:0]             gnt_idx;
  logic                   sel_is_buy;
  logic [PRICE_WIDTH-1:0] sel_price;
  logic [QTY_WIDTH-1:0]   sel_qty;
  logic [ID_WIDTH-1:0]    sel_id;

  // Handshake: req_ready is the registered "holding register empty" flag and never looks at
  // req_valid; a transfer happens at any edge where req_valid && req_ready.
  assign req_ready = ~hold_valid_q;
  assign fsm_state = logic'(state_q);
  assign hv_pad    = 8'(hold_valid_q);

  always_comb begin
    accept       = '0;
    reject       = '0;
    hold_valid_d = '0;
    reject_inc   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      accept[i] = req_valid[i] && !hold_valid_q[i];
      reject[i] = accept[i] && (req_qty[i*QTY_WIDTH +: QTY_WIDTH] == '0);
      if (reject[i]) reject_inc = reject_inc + 32'd1;
      hold_valid_d[i] = (hold_valid_q[i] && !gnt_oh[i]) || (accept[i] && !reject[i]);
    end
  end

  // First pending port at or above the RR pointer, wrapping modulo NUM_PORTS.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan = {1'b0, rr_q} + 4'(k);
      if (scan >= 4'(NUM_PORTS)) scan = scan - 4'(NUM_PORTS);
      if (!gnt_found && hv_pad[scan[2:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[2:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ARB;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_ARB: if (grant_en && MIN_GAP != 0) begin
        state_d   = ST_GAP;
        gap_cnt_d = 4'(MIN_GAP);
      end
      ST_GAP: if (gap_cnt_q <= 4'd1) begin
        state_d   = ST_ARB;
        gap_cnt_d = '0;
      end else begin
        gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_comb begin
    grant_en = (state_q == ST_ARB) && !pause && gnt_found;
    gnt_oh   = '0;
    for (int i = 0; i < NUM_PORTS; i++) gnt_oh[i] = grant_en && (gnt_idx == 3'(i));
  end

  always_comb begin
    sel_is_buy = 1'b0;
    sel_price  = '0;
    sel_qty    = '0;
    sel_id     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_oh[i]) begin
        sel_is_buy = hold_is_buy_q[i];
        sel_price  = hold_price_q[i];
        sel_qty    = hold_qty_q[i];
        sel_id     = hold_id_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= '0;
      rr_q         <= '0;
      order_valid  <= 1'b0;
      order_is_buy <= 1'b0;
      order_price  <= '0;
      order_qty    <= '0;
      order_id     <= '0;
      order_port   <= '0;
      issued_count <= '0;
      reject_count <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (accept[i]) begin
          hold_is_buy_q[i] <= req_is_buy[i];
          hold_price_q[i]  <= req_price[i*PRICE_WIDTH +: PRICE_WIDTH];
          hold_qty_q[i]    <= req_qty[i*QTY_WIDTH +: QTY_WIDTH];
          hold_id_q[i]     <= req_id[i*ID_WIDTH +: ID_WIDTH];
        end
      end
      order_valid <= grant_en;
      if (grant_en) begin
        order_is_buy <= sel_is_buy;
        order_price  <= sel_price;
        order_qty    <= sel_qty;
        order_id     <= sel_id;
        order_port   <= gnt_idx;
        rr_q         <= (gnt_idx == 3'(NUM_PORTS - 1)) ? 3'd0 : gnt_idx + 3'd1;
        issued_count <= issued_count + 32'd1;
      end
      reject_count <= reject_count + reject_inc;
    end
  end

`ifdef ARB_PORT_COUNTERS_EN
  logic [31:0] port_cnt_q [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) port_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) if (gnt_oh[i]) port_cnt_q[i] <= port_cnt_q[i] + 32'd1;
    end
  end

  always_comb begin
    port_issued = '0;
    for (int i = 0; i < NUM_PORTS; i++) port_issued[i*32 +: 32] = port_cnt_q[i];
  end
`else
  assign port_issued = '0;
`endif

endmodule

// File: tb/tb_order_ingress_arbiter.sv
// Bench for order_ingress_arbiter: scoreboard on the MIN_GAP=0 instance, directed timing on a MIN_GAP=3 instance.
module tb_order_ingress_arbiter;
  localparam int NP = 4;
  localparam int PW = 32;
  localparam int QW = 16;
  localparam int IW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   req_valid, g_req_valid, req_ready, g_req_ready, req_is_buy;
  logic [NP*PW-1:0] req_price;
  logic [NP*QW-1:0] req_qty;
  logic [NP*IW-1:0] req_id;
  logic            pause;
  logic            order_valid, order_is_buy, fsm_state;
  logic [PW-1:0]   order_price;
  logic [QW-1:0]   order_qty;
  logic [IW-1:0]   order_id;
  logic [2:0]      order_port;
  logic [31:0]     issued_count, reject_count;
  logic [NP*32-1:0] port_issued;
  logic            g_order_valid, g_order_is_buy, g_fsm_state;
  logic [PW-1:0]   g_order_price;
  logic [QW-1:0]   g_order_qty;
  logic [IW-1:0]   g_order_id;
  logic [2:0]      g_order_port;
  logic [31:0]     g_issued_count, g_reject_count;
  logic [NP*32-1:0] g_port_issued;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [67:0] exp_q[$];
  logic [67:0] sb_exp;
  logic [15:0] qty2;
  logic [5:0]  gap_pat;

  // clock / reset
  always #5 clk = ~clk;

  order_ingress_arbiter #(.NUM_PORTS(NP), .MIN_GAP(0)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_buy(req_is_buy), .req_price(req_price), .req_qty(req_qty), .req_id(req_id),
    .pause(pause), .order_valid(order_valid), .order_is_buy(order_is_buy),
    .order_price(order_price), .order_qty(order_qty), .order_id(order_id),
    .order_port(order_port), .issued_count(issued_count), .reject_count(reject_count),
    .port_issued(port_issued), .fsm_state(fsm_state)
  );

  order_ingress_arbiter #(.NUM_PORTS(NP), .MIN_GAP(3)) u_gap (
    .clk(clk), .rst(rst), .req_valid(g_req_valid), .req_ready(g_req_ready),
    .req_is_buy(req_is_buy), .req_price(req_price), .req_qty(req_qty), .req_id(req_id),
    .pause(pause), .order_valid(g_order_valid), .order_is_buy(g_order_is_buy),
    .order_price(g_order_price), .order_qty(g_order_qty), .order_id(g_order_id),
    .order_port(g_order_port), .issued_count(g_issued_count), .reject_count(g_reject_count),
    .port_issued(g_port_issued), .fsm_state(g_fsm_state)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks; tgt 0 = main instance scoreboarded, 1 = gap instance, 2 = main without scoreboard
  task automatic load_port(input int p, input int tgt, input logic buy, input logic [31:0] price,
                           input logic [15:0] qty, input logic [15:0] id);
    req_is_buy[p]        = buy;
    req_price[p*PW +: PW] = price;
    req_qty[p*QW +: QW]   = qty;
    req_id[p*IW +: IW]    = id;
    if (tgt == 1) g_req_valid[p] = 1'b1;
    else          req_valid[p]   = 1'b1;
    if (tgt == 0 && qty != 16'd0) exp_q.push_back({buy, price, qty, id, 3'(p)});
  endtask

  task automatic load_rand(input int p, input int tgt);
    load_port(p, tgt, 1'($urandom_range(0, 1)), $urandom, 16'($urandom_range(1, 65535)),
              16'($urandom_range(0, 65535)));
  endtask

  task automatic do_reset();
    pause       = 1'b0;
    req_valid   = '0;
    g_req_valid = '0;
    rst         = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // scoreboard: every pulse of the main instance must match the oldest expected order
  always @(negedge clk) begin
    if (order_valid === 1'b1) begin
      if (exp_q.size() == 0) check("sb_pulse_without_expected", 96'(exp_q.size()), 96'd1);
      else begin
        sb_exp = exp_q.pop_front();
        check("sb_order", 96'({order_is_buy, order_price, order_qty, order_id, order_port}), 96'(sb_exp));
      end
    end
  end

  initial begin
    rst = 1'b1; pause = 1'b0; req_valid = '0; g_req_valid = '0;
    req_is_buy = '0; req_price = '0; req_qty = '0; req_id = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_ready", 96'(req_ready), 96'hF);
    check("rst_order_valid", 96'(order_valid), 96'd0);
    check("rst_payload", 96'({order_is_buy, order_price, order_qty, order_id, order_port}), 96'd0);
    check("rst_issued", 96'(issued_count), 96'd0);
    check("rst_reject", 96'(reject_count), 96'd0);
    check("rst_port_issued", 96'(port_issued), 96'd0);
    check("rst_state", 96'(fsm_state), 96'd0);

    // single port latency and payload
    load_port(1, 0, 1'b1, 32'd100, 16'd5, 16'd7);
    @(negedge clk); req_valid = '0;
    check("t1_ready_after_accept", 96'(req_ready), 96'b1101);
    check("t1_no_pulse_yet", 96'(order_valid), 96'd0);
    @(negedge clk);
    check("t1_pulse", 96'(order_valid), 96'd1);
    check("t1_port", 96'(order_port), 96'd1);
    check("t1_issued", 96'(issued_count), 96'd1);
    @(negedge clk);
    check("t1_pulse_one_cycle", 96'(order_valid), 96'd0);
    check("t1_payload_held", 96'({order_is_buy, order_price, order_qty, order_id}), 96'({1'b1, 32'd100, 16'd5, 16'd7}));
    check("t1_ready_back", 96'(req_ready), 96'hF);

    // all four ports at once, then refill port 0
    do_reset();
    for (int p = 0; p < NP; p++) load_rand(p, 0);
    @(negedge clk); req_valid = '0;
    check("t2_all_held", 96'(req_ready), 96'd0);
    @(negedge clk);
    check("t2_pulse0", 96'(order_valid), 96'd1);
    load_rand(0, 0);
    @(negedge clk); req_valid = '0;
    check("t2_pulse1", 96'(order_valid), 96'd1);
    for (int c = 2; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("t2_pulse%0d", c), 96'(order_valid), 96'd1);
    end
    @(negedge clk);
    check("t2_idle_after", 96'(order_valid), 96'd0);
    check("t2_issued", 96'(issued_count), 96'd5);
`ifdef ARB_PORT_COUNTERS_EN
    check("t2_port_issued", 96'(port_issued), 96'({32'd1, 32'd1, 32'd1, 32'd2}));
`else
    check("t2_port_issued_tied", 96'(port_issued), 96'd0);
`endif

    // pause holds issuing but not acceptance
    do_reset();
    pause = 1'b1;
    load_rand(0, 0);
    load_rand(3, 0);
    @(negedge clk); req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      check("t3_paused_no_pulse", 96'(order_valid), 96'd0);
      @(negedge clk);
    end
    check("t3_ready_paused", 96'(req_ready), 96'b0110);
    pause = 1'b0;
    @(negedge clk);
    check("t3_first_after_pause", 96'(order_valid), 96'd1);
    @(negedge clk);
    check("t3_second_after_pause", 96'(order_valid), 96'd1);
    @(negedge clk);
    check("t3_drained", 96'(order_valid), 96'd0);

    // simultaneous zero-quantity rejects
    do_reset();
    load_port(1, 0, 1'b0, $urandom, 16'd0, 16'($urandom_range(0, 65535)));
    load_port(2, 0, 1'b1, $urandom, 16'd0, 16'($urandom_range(0, 65535)));
    @(negedge clk); req_valid = '0;
    check("t4_reject_count", 96'(reject_count), 96'd2);
    check("t4_ready_stays", 96'(req_ready), 96'hF);
    repeat (3) begin
      @(negedge clk);
      check("t4_no_pulse", 96'(order_valid), 96'd0);
    end

    // reset while three ports hold orders
    pause = 1'b1;
    for (int p = 0; p < 3; p++) load_rand(p, 2);
    @(negedge clk); req_valid = '0;
    check("t5_held", 96'(req_ready), 96'b1000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; pause = 1'b0;
    check("t5_ready_cleared", 96'(req_ready), 96'hF);
    check("t5_issued_cleared", 96'(issued_count), 96'd0);
    check("t5_reject_cleared", 96'(reject_count), 96'd0);
    check("t5_port_issued_cleared", 96'(port_issued), 96'd0);
    repeat (5) begin
      @(negedge clk);
      check("t5_no_pulse", 96'(order_valid), 96'd0);
    end

    // MIN_GAP = 3 instance: port 0, three idle cycles, port 2
    do_reset();
    load_rand(0, 1);
    load_rand(2, 1);
    qty2 = req_qty[2*QW +: QW];
    gap_pat = 6'b010001;
    @(negedge clk); g_req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("gap_valid_c%0d", c), 96'(g_order_valid), 96'(gap_pat[c]));
      if (c == 0) check("gap_first_port", 96'(g_order_port), 96'd0);
      if (c == 0) check("gap_state_gap", 96'(g_fsm_state), 96'd1);
      if (c == 3) check("gap_state_arb", 96'(g_fsm_state), 96'd0);
      if (c == 4) check("gap_second_port", 96'(g_order_port), 96'd2);
      if (c == 4) check("gap_second_qty", 96'(g_order_qty), 96'(qty2));
    end
    check("gap_issued", 96'(g_issued_count), 96'd2);

    check("sb_drained", 96'(exp_q.size()), 96'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
